fpu_sub_seq: RTL and testbench

Multi-cycle IEEE-754 single-precision subtractor computing `diff = a - b`: the inverse-direction companion to the team's combinational floating-point adder. It serves area-constrained datapaths that can afford variable latency. Alignment and normalisation are done one bit per clock, so the block needs no barrel shifters. Operands enter and results leave on valid/ready handshakes.

---
 rtl/fpu_pkg.sv | 19 +
 rtl/fpu_operand_unpack.sv | 23 ++
 rtl/fpu_sub_seq.sv | 153 +++++++++++++++
 tb/tb_fpu_sub_seq.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared constants and state encoding for the sequential floating-point blocks.
package fpu_pkg;

  localparam int unsigned E_SIZE    = 8;
  localparam int unsigned M_SIZE    = 23;
  localparam int unsigned BIAS      = 127;
  localparam logic [31:0] QNAN      = 32'h7FC0_0000;
  localparam int unsigned SHIFT_MAX = 25;
  localparam int unsigned CNT_W     = $clog2(SHIFT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    DONE
  } state_t;

endpackage

// File: rtl/fpu_operand_unpack.sv
// Splits a packed single-precision word into sign, exponent and hidden-bit mantissa.
module fpu_operand_unpack #(
  parameter int unsigned E_SIZE = 8,
  parameter int unsigned M_SIZE = 23
) (
  input  logic [E_SIZE+M_SIZE:0] word,
  output logic                   sign,
  output logic [E_SIZE-1:0]      expo,
  output logic [M_SIZE:0]        mant,
  output logic                   is_zero,
  output logic                   is_special
);

  always_comb begin
    sign       = word[E_SIZE+M_SIZE];
    expo       = word[E_SIZE+M_SIZE-1:M_SIZE];
    is_zero    = (expo == '0);
    is_special = (expo == '1);
    // Denormals flush to zero: the whole mantissa is dropped, not just the hidden bit.
    mant       = is_zero ? '0 : {1'b1, word[M_SIZE-1:0]};
  end

endmodule

// File: rtl/fpu_sub_seq.sv
// Multi-cycle single-precision subtractor (diff = a - b) with one-bit-per-clock
// alignment and normalisation, truncating rounding, valid/ready on both sides.
module fpu_sub_seq
  import fpu_pkg::state_t, fpu_pkg::IDLE, fpu_pkg::ALIGN, fpu_pkg::ADD,
         fpu_pkg::NORM, fpu_pkg::DONE, fpu_pkg::QNAN, fpu_pkg::SHIFT_MAX,
         fpu_pkg::CNT_W;
#(
  parameter int unsigned M_SIZE     = 23,
  parameter int unsigned E_SIZE     = 8,
  parameter int unsigned TOTAL_SIZE = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [TOTAL_SIZE-1:0] a,
  input  logic [TOTAL_SIZE-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TOTAL_SIZE-1:0] diff,
  output logic                  ovf,
  output logic                  unf,
  output logic                  inv
);

  state_t state, state_nxt;

  logic                  sa, sb, za, zb, xa, xb;
  logic [E_SIZE-1:0]     ea, eb;
  logic [M_SIZE:0]       ma, mb;

  logic [TOTAL_SIZE-2:0] key_a, key_b;
  logic                  swap, special, accept;
  logic                  sx_in, sy_in;
  logic [E_SIZE-1:0]     ex_in, ey_in, d;
  logic [M_SIZE:0]       mx_in, my_in;
  logic [CNT_W-1:0]      cnt_in;

  logic                  sign_r, eff_sub;
  logic [E_SIZE-1:0]     exp_r;
  logic [M_SIZE:0]       mx, my;
  logic [M_SIZE+1:0]     sum, sum_w;
  logic [CNT_W-1:0]      cnt;
  logic                  norm_done;

  fpu_operand_unpack #(.E_SIZE(E_SIZE), .M_SIZE(M_SIZE)) u_unpack_a (
    .word(a), .sign(sa), .expo(ea), .mant(ma), .is_zero(za), .is_special(xa)
  );

  fpu_operand_unpack #(.E_SIZE(E_SIZE), .M_SIZE(M_SIZE)) u_unpack_b (
    .word(b), .sign(sb), .expo(eb), .mant(mb), .is_zero(zb), .is_special(xb)
  );

  // Operand ordering: b enters with its sign inverted; ties keep a as X.
  always_comb begin
    key_a   = za ? '0 : a[TOTAL_SIZE-2:0];
    key_b   = zb ? '0 : b[TOTAL_SIZE-2:0];
    swap    = (key_b > key_a);
    special = xa | xb;
    accept  = in_valid & in_ready;
    if (swap) begin
      sx_in = ~sb; ex_in = eb; mx_in = mb;
      sy_in = sa;  ey_in = ea; my_in = ma;
    end else begin
      sx_in = sa;  ex_in = ea; mx_in = ma;
      sy_in = ~sb; ey_in = eb; my_in = mb;
    end
    d      = ex_in - ey_in;
    cnt_in = (32'(d) > SHIFT_MAX) ? CNT_W'(SHIFT_MAX) : d[CNT_W-1:0];
    sum_w  = eff_sub ? ({1'b0, mx} - {1'b0, my}) : ({1'b0, mx} + {1'b0, my});
    norm_done = ovf | unf | (sum == '0) | (!sum[M_SIZE+1] && sum[M_SIZE]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = special ? DONE : ALIGN;
      ALIGN:   if (cnt == '0) state_nxt = ADD;
      ADD:     state_nxt = NORM;
      NORM:    if (norm_done) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = rst_n && (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sign_r  <= 1'b0;
      eff_sub <= 1'b0;
      exp_r   <= '0;
      mx      <= '0;
      my      <= '0;
      sum     <= '0;
      cnt     <= '0;
      diff    <= '0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
      inv     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          sign_r  <= sx_in;
          eff_sub <= sx_in ^ sy_in;
          exp_r   <= ex_in;
          mx      <= mx_in;
          my      <= my_in;
          cnt     <= cnt_in;
          ovf     <= 1'b0;
          unf     <= 1'b0;
          inv     <= special;
          if (special) diff <= TOTAL_SIZE'(QNAN);
        end
        ALIGN: if (cnt != '0) begin
          my  <= my >> 1;
          cnt <= cnt - 1'b1;
        end
        ADD: sum <= sum_w;
        // Overflow/underflow are flagged on the shift and packed on the following cycle.
        NORM: begin
          if (ovf) begin
            diff <= {sign_r, {E_SIZE{1'b1}}, {M_SIZE{1'b0}}};
          end else if (unf) begin
            diff <= {sign_r, {(TOTAL_SIZE-1){1'b0}}};
          end else if (sum == '0) begin
            diff <= '0;
          end else if (sum[M_SIZE+1]) begin
            sum   <= sum >> 1;
            exp_r <= exp_r + 1'b1;
            if (exp_r == {{(E_SIZE-1){1'b1}}, 1'b0}) ovf <= 1'b1;
          end else if (!sum[M_SIZE]) begin
            sum   <= sum << 1;
            exp_r <= exp_r - 1'b1;
            if (exp_r == E_SIZE'(1)) unf <= 1'b1;
          end else begin
            diff <= {sign_r, exp_r, sum[M_SIZE-1:0]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_sub_seq.sv
// Scoreboard bench for fpu_sub_seq: stimulus queues expected results, monitor checks them.
module tb_fpu_sub_seq;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, diff;
  logic        ovf, unf, inv;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] diff;
    logic        ovf, unf, inv;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   shown = 0;

  fpu_sub_seq #(.M_SIZE(23), .E_SIZE(8), .TOTAL_SIZE(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .ovf(ovf), .unf(unf), .inv(inv)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: latency is counted in clock edges from the accept edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      shown = 0;
    end else if (out_valid) begin
      if (!shown) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          cur = exp_q.pop_front();
          shown = 1;
          check("diff", diff, cur.diff);
          check("flags{ovf,unf,inv}", {29'd0, ovf, unf, inv}, {29'd0, cur.ovf, cur.unf, cur.inv});
          check("latency", 32'(cyc - cur.acc), 32'(cur.lat));
        end
      end else begin
        check("diff_hold", diff, cur.diff);
        check("in_ready_while_done", 32'(in_ready), 32'd0);
      end
      if (out_ready) shown = 0;
    end
  end

  task automatic issue(input logic [31:0] va, input logic [31:0] vb, input logic [31:0] ed,
                       input logic eo, input logic eu, input logic ei, input int lat,
                       input bit push);
    exp_t e;
    int t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    a = va; b = vb; in_valid = 1'b1;
    if (push) begin
      e.diff = ed; e.ovf = eo; e.unf = eu; e.inv = ei; e.lat = lat; e.acc = cyc + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; a = 32'h4040_0000; b = 32'h3F80_0000;
    repeat (3) @(negedge clk);
    check("reset_handshake{in_ready,out_valid}", {30'd0, in_ready, out_valid}, 32'd0);
    check("reset_outputs", diff | {29'd0, ovf, unf, inv}, 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", 32'(in_ready), 32'd1);
    check("no_op_from_reset_in_valid", 32'(out_valid), 32'd0);

    //     a             b             diff          ovf   unf   inv   edges
    issue(32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 3, 1);
    issue(32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b0, 4, 1);
    issue(32'h3F80_0000, 32'h4040_0000, 32'hC000_0000, 1'b0, 1'b0, 1'b0, 4, 1);
    issue(32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b0, 4, 1);
    issue(32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 1'b1, 1'b0, 1'b0, 4, 1);
    issue(32'h0080_0001, 32'h0080_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 4, 1);
    // Special operands enter DONE on the accept edge itself.
    issue(32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 1'b0, 1'b1, 0, 1);
    issue(32'h3F80_0000, 32'hFFC0_0000, 32'h7FC0_0000, 1'b0, 1'b0, 1'b1, 0, 1);
    issue(32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 3, 1);
    issue(32'h4120_0000, 32'h3F80_0000, 32'h4110_0000, 1'b0, 1'b0, 1'b0, 6, 1);
    issue(32'h3FC0_0000, 32'h3F80_0000, 32'h3F00_0000, 1'b0, 1'b0, 1'b0, 4, 1);
    issue(32'h4F80_0000, 32'h3F80_0000, 32'h4F80_0000, 1'b0, 1'b0, 1'b0, 28, 1);
    issue(32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 1'b0, 1'b0, 1'b0, 27, 1);
    wait_drain();

    out_ready = 1'b0;
    issue(32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b0, 4, 1);
    begin
      int t = 0;
      while (!out_valid && t < 50) begin
        @(negedge clk);
        t++;
      end
      check("backpressure_out_valid", 32'(out_valid), 32'd1);
    end
    repeat (10) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    check("in_ready_after_handshake", 32'(in_ready), 32'd1);
    wait_drain();

    issue(32'h4980_0000, 32'h3F80_0000, 32'h0, 1'b0, 1'b0, 1'b0, 0, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_in_reset{in_ready,out_valid}", {30'd0, in_ready, out_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_back_to_idle", 32'(in_ready), 32'd1);
    begin
      int seen = 0;
      repeat (30) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      check("abort_no_out_valid", 32'(seen), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
